oram_code_writer: RTL and testbench

//  Write-side counterpart of the IRAM operand/count readers. Accepts 32-bit ARM

---
 rtl/oram_code_writer_pkg.sv | 12 +
 rtl/oram_code_writer.sv | 115 +++++++++++
 tb/tb_oram_code_writer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/oram_code_writer_pkg.sv
// Shared constants and types for the ORAM code writer.
package oram_code_writer_pkg;

  localparam int unsigned ORAM_ADDR_W    = 12;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic {
    WR_IDLE  = 1'b0,
    WR_WRITE = 1'b1
  } wr_state_t;

endpackage

// File: rtl/oram_code_writer.sv
// Serialises 32-bit instruction words into little-endian byte writes to the
// output code RAM, tracking write pointer, word count, fullness and overflow.
module oram_code_writer
  import oram_code_writer_pkg::*;
#(
  parameter int unsigned ADDR_W = ORAM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [31:0]       in_word,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] oram_addr,
  output logic [7:0]        oram_data,
  output logic              oram_we,
  output logic [ADDR_W-2:0] word_count,
  output logic              busy,
  output logic              full,
  output logic              overflow
);

  localparam logic [ADDR_W:0] DEPTH      = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] FULL_LIMIT = DEPTH - (ADDR_W+1)'(BYTES_PER_WORD);

  wr_state_t       state_q, state_d;
  logic [ADDR_W:0] ptr;
  logic [1:0]      byte_idx;
  logic [31:0]     shreg;
  logic [ADDR_W:0] bytes_left;
  logic [ADDR_W:0] ptr_end;
  logic            last_byte;
  logic            accept;

  // Fullness is judged on where the pointer lands once the in-flight word
  // completes, so a back-to-back word is only accepted if it fits entirely.
  always_comb begin
    bytes_left = '0;
    if (state_q == WR_WRITE) begin
      bytes_left = (ADDR_W+1)'(3'd4 - {1'b0, byte_idx});
    end
    ptr_end   = ptr + bytes_left;
    full      = (ptr_end > FULL_LIMIT);
    last_byte = (state_q == WR_WRITE) && (byte_idx == 2'd3);
    in_ready  = ~start & ~full & ((state_q == WR_IDLE) | last_byte);
    accept    = in_valid & in_ready;
    busy      = (state_q == WR_WRITE);
  end

  // Next-state logic: start aborts, accept (re)enters WRITE, last byte ends it.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = WR_IDLE;
    end else if (accept) begin
      state_d = WR_WRITE;
    end else if (last_byte) begin
      state_d = WR_IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= WR_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: byte serialiser, pointer, counters and registered ORAM port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr        <= '0;
      byte_idx   <= '0;
      shreg      <= '0;
      oram_addr  <= '0;
      oram_data  <= '0;
      oram_we    <= 1'b0;
      word_count <= '0;
      overflow   <= 1'b0;
    end else if (start) begin
      ptr        <= {1'b0, base_addr};
      byte_idx   <= '0;
      oram_we    <= 1'b0;
      word_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (in_valid && full) begin
        overflow <= 1'b1;
      end
      if (state_q == WR_WRITE) begin
        oram_we   <= 1'b1;
        oram_addr <= ptr[ADDR_W-1:0];
        oram_data <= shreg[7:0];
        shreg     <= {8'h00, shreg[31:8]};
        ptr       <= ptr + (ADDR_W+1)'(1);
        byte_idx  <= byte_idx + 2'd1;
        if (byte_idx == 2'd3) begin
          word_count <= word_count + (ADDR_W-1)'(1);
        end
      end else begin
        oram_we <= 1'b0;
      end
      // A word accepted on the last byte overrides the shift so the next
      // word's byte 0 follows without a bubble.
      if (accept) begin
        shreg    <= in_word;
        byte_idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_oram_code_writer.sv
// Directed self-checking bench for oram_code_writer (ADDR_W = 12).
module tb_oram_code_writer;

  localparam int unsigned AW = 12;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [31:0]   in_word;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] oram_addr;
  logic [7:0]    oram_data;
  logic          oram_we;
  logic [AW-2:0] word_count;
  logic          busy;
  logic          full;
  logic          overflow;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] wbuf [0:3];
  int          log_cyc  [$];
  logic [31:0] log_addr [$];
  logic [31:0] log_data [$];

  oram_code_writer #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .in_word    (in_word),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .oram_addr  (oram_addr),
    .oram_data  (oram_data),
    .oram_we    (oram_we),
    .word_count (word_count),
    .busy       (busy),
    .full       (full),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every ORAM write, sampled mid-cycle.
  always @(negedge clk) begin
    if (oram_we) begin
      log_cyc.push_back(cyc);
      log_addr.push_back(32'(oram_addr));
      log_data.push_back(32'(oram_data));
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    log_cyc.delete();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [AW-1:0] base);
    base_addr = base;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Offers wbuf[0..n-1] in order, holding in_valid until all are accepted.
  task automatic send_words(input int n);
    int   idx;
    int   guard;
    logic acc;
    idx      = 0;
    guard    = 0;
    in_word  = wbuf[0];
    in_valid = 1'b1;
    while (idx < n && guard < 40) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
      if (acc) begin
        idx++;
        if (idx < n) in_word = wbuf[idx];
      end
    end
    in_valid = 1'b0;
    check("send_done", 32'(idx), 32'(n));
  endtask

  // Checks the logged writes against the little-endian bytes of wbuf words,
  // starting at address base, on consecutive cycles.
  task automatic check_log(input string tag, input int nwords, input logic [31:0] base);
    logic [31:0] w;
    check({tag, "_nwrites"}, 32'(log_addr.size()), 32'(nwords * 4));
    if (log_addr.size() == nwords * 4) begin
      for (int i = 0; i < nwords * 4; i++) begin
        w = wbuf[i / 4];
        check($sformatf("%s_addr%0d", tag, i), log_addr[i], base + 32'(i));
        check($sformatf("%s_data%0d", tag, i), log_data[i], 32'((w >> (8 * (i % 4))) & 32'hFF));
        if (i > 0) check($sformatf("%s_gap%0d", tag, i), 32'(log_cyc[i] - log_cyc[i-1]), 32'd1);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    in_word   = '0;
    in_valid  = 1'b0;

    // 1. Reset values
    wait_cycles(2);
    reset = 1'b0;
    #1;
    check("rst_we",       32'(oram_we),    32'd0);
    check("rst_wc",       32'(word_count), 32'd0);
    check("rst_in_ready", 32'(in_ready),   32'd1);
    check("rst_full",     32'(full),       32'd0);
    check("rst_overflow", 32'(overflow),   32'd0);
    check("rst_busy",     32'(busy),       32'd0);

    // 2. Single word at base 0x010
    pulse_start(12'h010);
    clear_log();
    wbuf[0] = 32'hE3A01005;
    send_words(1);
    wait_cycles(6);
    check_log("single", 1, 32'h010);
    check("single_wc", 32'(word_count), 32'd1);
    check("single_busy", 32'(busy), 32'd0);

    // 3. Three back-to-back words continue from ptr 0x014 (count 1 + 3)
    clear_log();
    wbuf[0] = 32'h11223344;
    wbuf[1] = 32'hA5A55A5A;
    wbuf[2] = 32'hDEADBEEF;
    send_words(3);
    wait_cycles(6);
    check_log("b2b", 3, 32'h014);
    check("b2b_wc", 32'(word_count), 32'd4);

    // 4. Near the top of ORAM: two words fit, third overflows
    pulse_start(12'hFF8);
    check("top_full0", 32'(full),       32'd0);
    check("top_wc0",   32'(word_count), 32'd0);
    clear_log();
    wbuf[0] = 32'h03020100;
    wbuf[1] = 32'h07060504;
    send_words(2);
    wait_cycles(6);
    check_log("top", 2, 32'hFF8);
    check("top_full",      32'(full),       32'd1);
    check("top_in_ready",  32'(in_ready),   32'd0);
    check("top_ovf_pre",   32'(overflow),   32'd0);
    check("top_wc",        32'(word_count), 32'd2);
    in_word  = 32'hCAFEF00D;
    in_valid = 1'b1;
    wait_cycles(3);
    in_valid = 1'b0;
    wait_cycles(4);
    check("top_overflow",  32'(overflow),         32'd1);
    check("top_in_ready2", 32'(in_ready),         32'd0);
    check("top_nwrites2",  32'(log_addr.size()),  32'd8);
    check("top_wc2",       32'(word_count),       32'd2);

    // 5. start on the third byte aborts the word
    pulse_start(12'h200);
    check("abort_ovf_clr", 32'(overflow), 32'd0);
    check("abort_full",    32'(full),     32'd0);
    clear_log();
    wbuf[0] = 32'h11223344;
    send_words(1);              // accept edge N has passed
    wait_cycles(2);             // bytes 0 and 1 written at N+1, N+2
    check("abort_we_b1", 32'(oram_we), 32'd1);
    base_addr = 12'h200;
    start     = 1'b1;           // applied at edge N+3 (third byte)
    @(posedge clk);
    #1;
    start = 1'b0;
    check("abort_we",      32'(oram_we),          32'd0);
    check("abort_busy",    32'(busy),             32'd0);
    wait_cycles(4);
    check("abort_nwrites", 32'(log_addr.size()),  32'd2);
    check("abort_wc",      32'(word_count),       32'd0);
    clear_log();
    wbuf[0] = 32'hAABBCCDD;
    send_words(1);
    wait_cycles(6);
    check_log("after_abort", 1, 32'h200);
    check("after_abort_wc", 32'(word_count), 32'd1);

    // 6. Asynchronous reset mid-word
    pulse_start(12'h300);
    clear_log();
    wbuf[0] = 32'h55667788;
    send_words(1);
    @(posedge clk);
    #2;
    check("arst_we_pre", 32'(oram_we), 32'd1);
    clear_log();
    reset = 1'b1;
    #1;
    check("arst_we",       32'(oram_we),    32'd0);
    check("arst_wc",       32'(word_count), 32'd0);
    check("arst_addr",     32'(oram_addr),  32'd0);
    check("arst_data",     32'(oram_data),  32'd0);
    check("arst_busy",     32'(busy),       32'd0);
    check("arst_in_ready", 32'(in_ready),   32'd1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    wait_cycles(5);
    check("arst_nwrites",  32'(log_addr.size()), 32'd0);
    check("arst_full",     32'(full),            32'd0);
    check("arst_overflow", 32'(overflow),        32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the bench always terminates.
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: got running expected finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
